uart_io_unit: RTL and testbench



---
 rtl/io_pkg.sv | 24 ++
 rtl/uart_io_unit_if.sv | 22 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/uart_io_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_io_unit.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// Shared types and constants for the core's serial I/O responder.
package io_pkg;

   localparam int UART_DATA_BITS = 8;

   localparam logic [5:0] OP_OUT = 6'b011011;
   localparam logic [5:0] OP_IN  = 6'b011010;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_IDLE
   } rx_state_t;

endpackage

// File: rtl/uart_io_unit_if.sv
// Core-side byte handshake: OUT pushes bytes to transmit, IN pulls received bytes.
interface uart_io_unit_if;
   import io_pkg::*;

   logic                      out_valid;
   logic [UART_DATA_BITS-1:0] out_data;
   logic                      out_ready;
   logic                      in_valid;
   logic [UART_DATA_BITS-1:0] in_data;
   logic                      in_ready;

   modport master (
      output out_valid, out_data, in_ready,
      input  out_ready, in_valid, in_data
   );

   modport slave (
      input  out_valid, out_data, in_ready,
      output out_ready, in_valid, in_data
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data (zero while empty).
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   // A push into a full FIFO still lands when the same cycle frees a slot.
   always_comb begin
      do_pop  = pop_i && (count_q != '0);
      do_push = push_i && ((count_q != DEPTH_C) || do_pop);
      wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = do_pop  ? rptr_q + AW'(1) : rptr_q;
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + (AW+1)'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == DEPTH_C);
   assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/uart_io_unit.sv
// OUT/IN responder: FIFO-buffered 8N1 transmitter and receiver on the board serial pins.
//
// TX state  | meaning                    RX state     | meaning
// TX_IDLE   | line high, waiting for FIFO RX_IDLE      | waiting for falling edge
// TX_START  | driving start bit           RX_START     | validating start at half bit
// TX_DATA   | shifting 8 bits, LSB first  RX_DATA      | sampling 8 bit centres
// TX_STOP   | driving stop bit            RX_STOP      | checking stop bit
//                                         RX_WAIT_IDLE | line held low after bad stop
module uart_io_unit
   import io_pkg::*;
#(
   parameter int CLK_PER_BIT = 868,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic          CLK,
   input  logic          RSTN,
   uart_io_unit_if.slave io,
   output logic          TXD,
   input  logic          RXD,
   output logic          rx_overrun,
   output logic          rx_frame_err
);

   localparam int TW = $clog2(CLK_PER_BIT);
   localparam logic [TW-1:0] TMR_LAST = TW'(CLK_PER_BIT - 1);
   localparam logic [TW-1:0] TMR_HALF = TW'(CLK_PER_BIT / 2);
   localparam logic [2:0]    BIT_LAST = 3'(UART_DATA_BITS - 1);

   logic                      tx_full, tx_empty, tx_pop;
   logic [UART_DATA_BITS-1:0] tx_head;
   logic                      rx_full, rx_empty, rx_push, rx_pop;

   tx_state_t                 tx_state_q, tx_state_d;
   logic [TW-1:0]             tx_tmr_q, tx_tmr_d;
   logic [2:0]                tx_bit_q, tx_bit_d;
   logic [UART_DATA_BITS-1:0] tx_shift_q, tx_shift_d;
   logic                      txd_q, txd_d;
   logic                      tx_tc;

   rx_state_t                 rx_state_q, rx_state_d;
   logic [1:0]                rx_sync_q;
   logic                      rxd_s;
   logic [TW-1:0]             rx_tmr_q, rx_tmr_d;
   logic [2:0]                rx_bit_q, rx_bit_d;
   logic [UART_DATA_BITS-1:0] rx_shift_q, rx_shift_d;
   logic                      rx_overrun_q, rx_overrun_d;
   logic                      rx_frame_err_q, rx_frame_err_d;
   logic                      rx_tc;

   sync_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk_i   (CLK),
      .rst_ni  (RSTN),
      .push_i  (io.out_valid && io.out_ready),
      .wdata_i (io.out_data),
      .pop_i   (tx_pop),
      .rdata_o (tx_head),
      .full_o  (tx_full),
      .empty_o (tx_empty)
   );

   sync_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk_i   (CLK),
      .rst_ni  (RSTN),
      .push_i  (rx_push),
      .wdata_i (rx_shift_q),
      .pop_i   (rx_pop),
      .rdata_o (io.in_data),
      .full_o  (rx_full),
      .empty_o (rx_empty)
   );

   assign io.out_ready = !tx_full;
   assign io.in_valid  = !rx_empty;
   assign rx_pop       = io.in_valid && io.in_ready;

   // ---------------- transmitter ----------------
   assign tx_tc = (tx_tmr_q == TMR_LAST);

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         tx_state_q <= TX_IDLE;
         tx_tmr_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         txd_q      <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_tmr_q   <= tx_tmr_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         txd_q      <= txd_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      case (tx_state_q)
         TX_IDLE:  if (!tx_empty) tx_state_d = TX_START;
         TX_START: if (tx_tc) tx_state_d = TX_DATA;
         TX_DATA:  if (tx_tc && (tx_bit_q == BIT_LAST)) tx_state_d = TX_STOP;
         TX_STOP:  if (tx_tc) tx_state_d = tx_empty ? TX_IDLE : TX_START;
         default:  tx_state_d = TX_IDLE;
      endcase
   end

   // Stop bit chains straight into the next start bit when more data is queued.
   always_comb begin
      tx_tmr_d   = tx_tc ? '0 : tx_tmr_q + TW'(1);
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      txd_d      = txd_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            tx_tmr_d = '0;
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_shift_d = tx_head;
               txd_d      = 1'b0;
            end
         end
         TX_START: begin
            if (tx_tc) begin
               txd_d    = tx_shift_q[0];
               tx_bit_d = '0;
            end
         end
         TX_DATA: begin
            if (tx_tc) begin
               if (tx_bit_q == BIT_LAST) begin
                  txd_d = 1'b1;
               end else begin
                  tx_shift_d = tx_shift_q >> 1;
                  txd_d      = tx_shift_q[1];
                  tx_bit_d   = tx_bit_q + 3'd1;
               end
            end
         end
         TX_STOP: begin
            if (tx_tc && !tx_empty) begin
               tx_pop     = 1'b1;
               tx_shift_d = tx_head;
               txd_d      = 1'b0;
            end
         end
         default: tx_tmr_d = '0;
      endcase
   end

   assign TXD = txd_q;

   // ---------------- receiver ----------------
   assign rxd_s = rx_sync_q[1];
   assign rx_tc = (rx_tmr_q == TMR_LAST);

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         rx_sync_q      <= 2'b11;
         rx_state_q     <= RX_IDLE;
         rx_tmr_q       <= '0;
         rx_bit_q       <= '0;
         rx_shift_q     <= '0;
         rx_overrun_q   <= 1'b0;
         rx_frame_err_q <= 1'b0;
      end else begin
         rx_sync_q      <= {rx_sync_q[0], RXD};
         rx_state_q     <= rx_state_d;
         rx_tmr_q       <= rx_tmr_d;
         rx_bit_q       <= rx_bit_d;
         rx_shift_q     <= rx_shift_d;
         rx_overrun_q   <= rx_overrun_d;
         rx_frame_err_q <= rx_frame_err_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      case (rx_state_q)
         RX_IDLE:      if (!rxd_s) rx_state_d = RX_START;
         RX_START:     if (rx_tmr_q == TMR_HALF) rx_state_d = rxd_s ? RX_IDLE : RX_DATA;
         RX_DATA:      if (rx_tc && (rx_bit_q == BIT_LAST)) rx_state_d = RX_STOP;
         RX_STOP:      if (rx_tc) rx_state_d = rxd_s ? RX_IDLE : RX_WAIT_IDLE;
         RX_WAIT_IDLE: if (rxd_s) rx_state_d = RX_IDLE;
         default:      rx_state_d = RX_IDLE;
      endcase
   end

   // A full RX FIFO only loses the byte when the core is not popping that cycle.
   always_comb begin
      rx_tmr_d       = rx_tmr_q + TW'(1);
      rx_bit_d       = rx_bit_q;
      rx_shift_d     = rx_shift_q;
      rx_push        = 1'b0;
      rx_overrun_d   = rx_overrun_q;
      rx_frame_err_d = rx_frame_err_q;
      case (rx_state_q)
         RX_IDLE: begin
            rx_tmr_d = '0;
            rx_bit_d = '0;
         end
         RX_START: begin
            if (rx_tmr_q == TMR_HALF) begin
               rx_tmr_d = '0;
               rx_bit_d = '0;
            end
         end
         RX_DATA: begin
            if (rx_tc) begin
               rx_tmr_d   = '0;
               rx_shift_d = {rxd_s, rx_shift_q[UART_DATA_BITS-1:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
            end
         end
         RX_STOP: begin
            if (rx_tc) begin
               rx_tmr_d = '0;
               if (rxd_s) begin
                  rx_push = 1'b1;
                  if (rx_full && !rx_pop) rx_overrun_d = 1'b1;
               end else begin
                  rx_frame_err_d = 1'b1;
               end
            end
         end
         default: rx_tmr_d = '0;
      endcase
   end

   assign rx_overrun   = rx_overrun_q;
   assign rx_frame_err = rx_frame_err_q;

endmodule

// File: tb/tb_uart_io_unit.sv
// Bench for uart_io_unit: frame-timing TX model, table-driven and randomized RX checks.
module tb_uart_io_unit;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;
   localparam int RX_SLOT = FRAME + 8;

   logic CLK = 1'b0;
   logic RSTN;
   logic TXD, RXD, rx_overrun, rx_frame_err;

   uart_io_unit_if io();

   uart_io_unit #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .CLK          (CLK),
      .RSTN         (RSTN),
      .io           (io),
      .TXD          (TXD),
      .RXD          (RXD),
      .rx_overrun   (rx_overrun),
      .rx_frame_err (rx_frame_err)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // TX reference: each frame is 40 cycles starting the edge after its byte is both
   // queued and the line is free; bit k of the frame is a fixed slice of that window.
   logic [7:0] m_txq[$];
   bit         m_act;
   int         m_start;
   logic [7:0] m_byte;
   int         now;

   function automatic logic exp_txd();
      int o;
      if (!m_act) return 1'b1;
      o = now - m_start;
      if (o < CPB) return 1'b0;
      if (o < 9 * CPB) return m_byte[(o - CPB) / CPB];
      return 1'b1;
   endfunction

   task automatic tx_step(input bit v, input logic [7:0] d);
      bit acc;
      io.out_valid = v;
      io.out_data  = d;
      acc = v && (m_txq.size() < DEPTH);
      @(posedge CLK);
      now++;
      if (!m_act || (now - m_start == FRAME)) begin
         if (m_txq.size() > 0) begin
            m_byte  = m_txq.pop_front();
            m_start = now;
            m_act   = 1'b1;
         end else begin
            m_act = 1'b0;
         end
      end
      if (acc) m_txq.push_back(d);
      #1;
      chk("txd", TXD, exp_txd());
      chk("out_ready", io.out_ready, m_txq.size() < DEPTH);
   endtask

   task automatic do_reset();
      RSTN = 1'b0;
      io.out_valid = 1'b0;
      io.out_data  = '0;
      io.in_ready  = 1'b0;
      RXD = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      RSTN = 1'b1;
      m_txq.delete();
      m_act = 1'b0;
   endtask

   // Drives one serial frame then idle; in_ready is high during slot cycle pulse_at.
   task automatic rx_frame(input logic [7:0] b, input bit stop, input int pulse_at);
      for (int k = 0; k < RX_SLOT; k++) begin
         if (k < CPB) RXD = 1'b0;
         else if (k < 9 * CPB) RXD = b[(k - CPB) / CPB];
         else if (k < 10 * CPB) RXD = stop;
         else RXD = 1'b1;
         io.in_ready = (k == pulse_at);
         @(posedge CLK);
         #1;
      end
      io.in_ready = 1'b0;
   endtask

   task automatic rx_pop();
      io.in_ready = 1'b1;
      @(posedge CLK);
      #1;
      io.in_ready = 1'b0;
      @(posedge CLK);
      #1;
   endtask

   task automatic rx_glitch();
      RXD = 1'b0;
      @(posedge CLK);
      #1;
      RXD = 1'b1;
      repeat (12) @(posedge CLK);
      #1;
   endtask

   typedef enum {ST_FRAME, ST_POP, ST_GLITCH} step_kind_e;
   typedef struct {
      step_kind_e kind;
      logic [7:0] b;
      bit         stop;
      bit         e_iv;
      logic [7:0] e_id;
      bit         e_ov;
      bit         e_fe;
   } rx_vec_t;

   rx_vec_t tbl[15];

   logic [7:0] r_q[$];
   bit         r_ov, r_fe;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{ST_FRAME,  8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
      tbl[1]  = '{ST_POP,    8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[2]  = '{ST_FRAME,  8'h10, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0};
      tbl[3]  = '{ST_FRAME,  8'h11, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0};
      tbl[4]  = '{ST_FRAME,  8'h12, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0};
      tbl[5]  = '{ST_FRAME,  8'h13, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0};
      tbl[6]  = '{ST_FRAME,  8'h14, 1'b1, 1'b1, 8'h10, 1'b1, 1'b0};
      tbl[7]  = '{ST_POP,    8'h00, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0};
      tbl[8]  = '{ST_POP,    8'h00, 1'b1, 1'b1, 8'h12, 1'b1, 1'b0};
      tbl[9]  = '{ST_POP,    8'h00, 1'b1, 1'b1, 8'h13, 1'b1, 1'b0};
      tbl[10] = '{ST_POP,    8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[11] = '{ST_FRAME,  8'h55, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
      tbl[12] = '{ST_GLITCH, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
      tbl[13] = '{ST_FRAME,  8'hA7, 1'b1, 1'b1, 8'hA7, 1'b1, 1'b1};
      tbl[14] = '{ST_POP,    8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};

      // Reset held with a pending OUT write: nothing may be accepted.
      RSTN = 1'b0;
      io.out_valid = 1'b1;
      io.out_data  = 8'hA5;
      io.in_ready  = 1'b0;
      RXD = 1'b1;
      now = 0;
      m_act = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK);
         #1;
         chk("rst_txd", TXD, 1'b1);
         chk("rst_out_ready", io.out_ready, 1'b1);
         chk("rst_in_valid", io.in_valid, 1'b0);
         chk("rst_in_data", io.in_data, 8'h00);
         chk("rst_overrun", rx_overrun, 1'b0);
         chk("rst_frame_err", rx_frame_err, 1'b0);
      end
      RSTN = 1'b1;
      for (int i = 0; i < 6; i++) tx_step(1'b0, 8'h00);

      // Single byte, then a 5-byte burst with out_valid held until accepted.
      tx_step(1'b1, 8'hA5);
      for (int i = 0; i < FRAME + 5; i++) tx_step(1'b0, 8'h00);
      for (int i = 1; i <= 5; i++) begin
         bit done;
         done = 1'b0;
         while (!done) begin
            done = (m_txq.size() < DEPTH);
            tx_step(1'b1, 8'(i));
         end
      end
      for (int i = 0; i < 6 * FRAME; i++) tx_step(1'b0, 8'h00);

      // Randomized OUT traffic.
      do_reset();
      for (int i = 0; i < 500; i++) tx_step(1'($urandom_range(0, 1)), 8'($urandom));
      for (int i = 0; i < (DEPTH + 2) * FRAME; i++) tx_step(1'b0, 8'h00);
      chk("tx_drained", {31'd0, m_act}, 32'd0);

      // Directed RX table.
      do_reset();
      for (int i = 0; i < 15; i++) begin
         case (tbl[i].kind)
            ST_FRAME:  rx_frame(tbl[i].b, tbl[i].stop, -1);
            ST_POP:    rx_pop();
            default:   rx_glitch();
         endcase
         chk($sformatf("rx_tbl%0d_in_valid", i), io.in_valid, tbl[i].e_iv);
         chk($sformatf("rx_tbl%0d_in_data", i), io.in_data, tbl[i].e_id);
         chk($sformatf("rx_tbl%0d_overrun", i), rx_overrun, tbl[i].e_ov);
         chk($sformatf("rx_tbl%0d_frame_err", i), rx_frame_err, tbl[i].e_fe);
      end

      // Full RX FIFO with a pop on the very cycle the 5th byte is pushed.
      do_reset();
      for (int i = 0; i < 4; i++) rx_frame(8'h20 + 8'(i), 1'b1, -1);
      chk("fullpop_pre_data", io.in_data, 8'h20);
      rx_frame(8'h24, 1'b1, 41);
      chk("fullpop_overrun", rx_overrun, 1'b0);
      chk("fullpop_head", io.in_data, 8'h21);
      for (int i = 2; i <= 4; i++) begin
         rx_pop();
         chk("fullpop_drain", io.in_data, 8'h20 + 8'(i));
      end
      rx_pop();
      chk("fullpop_empty", io.in_valid, 1'b0);

      // Randomized RX against a queue model.
      do_reset();
      r_q.delete();
      r_ov = 1'b0;
      r_fe = 1'b0;
      for (int i = 0; i < 12; i++) begin
         logic [7:0] b;
         bit stop;
         b = 8'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         rx_frame(b, stop, -1);
         if (!stop) r_fe = 1'b1;
         else if (r_q.size() < DEPTH) r_q.push_back(b);
         else r_ov = 1'b1;
         if ($urandom_range(0, 2) == 0) begin
            rx_pop();
            if (r_q.size() > 0) void'(r_q.pop_front());
         end
         chk("rxr_in_valid", io.in_valid, r_q.size() > 0);
         chk("rxr_in_data", io.in_data, (r_q.size() > 0) ? r_q[0] : 8'h00);
         chk("rxr_overrun", rx_overrun, r_ov);
         chk("rxr_frame_err", rx_frame_err, r_fe);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
